// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer: FSM states, opcodes
// and RegisterFile function selects.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_L,
        ST_FETCH_H,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;

endpackage

// File: rtl/seq_decode.sv
// Combinational decoder: turns the instruction register and FSM state into
// RegisterFile controls. Everything is idle (enables high, rest zero) outside EXEC.
module seq_decode
    import seq_pkg::*;
(
    input  logic [15:0] ir,
    input  seq_state_t  state,
    input  logic [15:0] reg_out_a,
    output logic [3:0]  reg_sel,
    output logic [3:0]  scr_sel,
    output logic [2:0]  fun_sel,
    output logic [2:0]  out_a_sel,
    output logic [2:0]  out_b_sel,
    output logic [15:0] idata
);

    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    logic [7:0] imm;
    logic       enable;
    logic [1:0] bit_idx;

    assign op  = ir[15:13];
    assign dst = ir[12:10];
    assign src = ir[9:7];
    assign imm = ir[7:0];

    // Bit (3-dst) for R and (7-dst) for S both reduce to the inverted low dst bits.
    assign bit_idx = ~dst[1:0];

    always_comb begin
        reg_sel   = '1;
        scr_sel   = '1;
        fun_sel   = FUN_DEC;
        out_a_sel = '0;
        out_b_sel = '0;
        idata     = '0;
        enable    = 1'b0;

        if (state == ST_EXEC) begin
            case (op)
                OP_CLR: begin
                    fun_sel = FUN_CLEAR;
                    enable  = 1'b1;
                end
                OP_INC: begin
                    fun_sel = FUN_INC;
                    enable  = 1'b1;
                end
                OP_DEC: begin
                    fun_sel = FUN_DEC;
                    enable  = 1'b1;
                end
                OP_LDI: begin
                    fun_sel = FUN_LOAD;
                    idata   = {8'h00, imm};
                    enable  = 1'b1;
                end
                OP_MOV: begin
                    fun_sel   = FUN_LOAD;
                    out_a_sel = src;
                    idata     = reg_out_a;
                    enable    = 1'b1;
                end
                default: enable = 1'b0;
            endcase

            if (enable) begin
                if (dst[2]) scr_sel[bit_idx] = 1'b0;
                else        reg_sel[bit_idx] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer driving a RegisterFile: two byte fetches then one EXEC cycle.
// Define SEQ_SINGLE_STEP_EN to return to IDLE after each instruction instead of free-running.
module instruction_sequencer
    import seq_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  MemData,
    input  logic [15:0] RegOutA,
    output logic [15:0] MemAddr,
    output logic [3:0]  RegSel,
    output logic [3:0]  ScrSel,
    output logic [2:0]  FunSel,
    output logic [2:0]  OutASel,
    output logic [2:0]  OutBSel,
    output logic [15:0] IData,
    output logic        Busy,
    output logic        Halted
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [15:0] pc;
    logic [15:0] ir;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_FETCH_L: begin
                    ir[7:0] <= MemData;
                    pc      <= pc + 16'd1;
                end
                ST_FETCH_H: begin
                    ir[15:8] <= MemData;
                    pc       <= pc + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (Start) state_next = ST_FETCH_L;
            ST_FETCH_L: state_next = ST_FETCH_H;
            ST_FETCH_H: state_next = ST_EXEC;
            ST_EXEC: begin
                if (ir[15:13] == OP_HALT) state_next = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
                else                      state_next = ST_IDLE;
`else
                else                      state_next = ST_FETCH_L;
`endif
            end
            ST_HALT:    state_next = ST_HALT;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign MemAddr = pc;
    assign Busy    = (state == ST_FETCH_L) || (state == ST_FETCH_H) || (state == ST_EXEC);
    assign Halted  = (state == ST_HALT);

    seq_decode u_decode (
        .ir        (ir),
        .state     (state),
        .reg_out_a (RegOutA),
        .reg_sel   (RegSel),
        .scr_sel   (ScrSel),
        .fun_sel   (FunSel),
        .out_a_sel (OutASel),
        .out_b_sel (OutBSel),
        .idata     (IData)
    );

endmodule
